// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_seq
// Brief  : Registered EX-stage ALU with valid/ready handshakes; iterative
//          unsigned MULTU/DIVU are built only when ALU_MULDIV_EN is defined.
// Rev    : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             div0
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] c_op_and  = 4'b0000;
  localparam logic [3:0] c_op_or   = 4'b0001;
  localparam logic [3:0] c_op_add  = 4'b0010;
  localparam logic [3:0] c_op_xor  = 4'b0011;
  localparam logic [3:0] c_op_sub  = 4'b0110;
  localparam logic [3:0] c_op_slt  = 4'b0111;
  localparam logic [3:0] c_op_sltu = 4'b1000;
  localparam logic [3:0] c_op_sll  = 4'b1001;
  localparam logic [3:0] c_op_srl  = 4'b1010;
  localparam logic [3:0] c_op_sra  = 4'b1011;
  localparam logic [3:0] c_op_nor  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic             r_zero, r_div0;
  logic [WIDTH-1:0] w_sc_lo, w_sc_hi;
  logic             w_sc_div0;
  logic             w_acc, w_iter, w_last;
  logic [SW-1:0]    w_sh;

  assign w_sh = b[SW-1:0];

  always_comb begin
    w_sc_lo   = '0;
    w_sc_hi   = '0;
    w_sc_div0 = 1'b0;
    case (op)
      c_op_and:  w_sc_lo = a & b;
      c_op_or:   w_sc_lo = a | b;
      c_op_add:  w_sc_lo = a + b;
      c_op_xor:  w_sc_lo = a ^ b;
      c_op_sub:  w_sc_lo = a - b;
      c_op_slt:  w_sc_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      c_op_sltu: w_sc_lo = {{(WIDTH-1){1'b0}}, a < b};
      c_op_sll:  w_sc_lo = a << w_sh;
      c_op_srl:  w_sc_lo = a >> w_sh;
      c_op_sra:  w_sc_lo = $signed(a) >>> w_sh;
      c_op_nor:  w_sc_lo = ~(a | b);
`ifdef ALU_MULDIV_EN
      // Reached in one cycle only for a zero divisor; other DIVUs iterate.
      4'b1110: begin
        w_sc_lo   = '1;
        w_sc_hi   = a;
        w_sc_div0 = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = SW + 1;
  localparam logic [3:0] c_op_multu = 4'b1101;
  localparam logic [3:0] c_op_divu  = 4'b1110;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_wlo, r_whi, r_wb;
  logic             r_mul;
  logic [WIDTH:0]   w_madd, w_rsh;
  logic [WIDTH-1:0] w_rsub, w_nlo, w_nhi;
  logic             w_ge;

  assign w_iter = (op == c_op_multu) || ((op == c_op_divu) && (b != '0));
  assign w_last = (r_state == S_BUSY) && (r_cnt == CW'(1));
  assign w_madd = {1'b0, r_whi} + (r_wlo[0] ? {1'b0, r_wb} : '0);
  assign w_rsh  = {r_whi, r_wlo[WIDTH-1]};
  assign w_ge   = w_rsh >= {1'b0, r_wb};
  // The true difference is below the divisor, so the low WIDTH bits suffice.
  assign w_rsub = w_rsh[WIDTH-1:0] - r_wb;

  always_comb begin
    if (r_mul) begin
      w_nhi = w_madd[WIDTH:1];
      w_nlo = {w_madd[0], r_wlo[WIDTH-1:1]};
    end else begin
      w_nhi = w_ge ? w_rsub : w_rsh[WIDTH-1:0];
      w_nlo = {r_wlo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_wlo <= '0;
      r_whi <= '0;
      r_wb  <= '0;
      r_mul <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_acc && w_iter) begin
      r_wlo <= a;
      r_whi <= '0;
      r_wb  <= b;
      r_mul <= (op == c_op_multu);
      r_cnt <= CW'(WIDTH);
    end else if (r_state == S_BUSY) begin
      r_wlo <= w_nlo;
      r_whi <= w_nhi;
      r_cnt <= r_cnt - CW'(1);
    end
  end
`else
  assign w_iter = 1'b0;
  assign w_last = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_DONE: begin
        in_ready = out_ready;
        if (out_ready) w_state_nx = S_IDLE;
      end
      S_BUSY: if (w_last) w_state_nx = S_DONE;
      default: w_state_nx = S_IDLE;
    endcase
    if (flush) begin
      in_ready   = 1'b0;
      w_state_nx = S_IDLE;
    end else if (in_valid && in_ready) begin
      w_state_nx = w_iter ? S_BUSY : S_DONE;
    end
  end

  assign w_acc = in_valid & in_ready;

  // Result registers move only when a result completes, never on consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_zero <= 1'b0;
      r_div0 <= 1'b0;
    end else if (!flush) begin
      if (w_acc && !w_iter) begin
        r_lo   <= w_sc_lo;
        r_hi   <= w_sc_hi;
        r_zero <= (w_sc_lo == '0);
        r_div0 <= w_sc_div0;
      end
`ifdef ALU_MULDIV_EN
      else if (w_last) begin
        r_lo   <= w_nlo;
        r_hi   <= w_nhi;
        r_zero <= (w_nlo == '0);
        r_div0 <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign out_lo    = r_lo;
  assign out_hi    = r_hi;
  assign zero      = r_zero;
  assign div0      = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// tb_alu_seq: directed bench for alu_seq; a cycle-level reference model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_alu_seq;
  localparam int W  = 32;
  localparam int SW = $clog2(W);

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   op        = '0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready, out_valid, zero, div0;
  logic [W-1:0] out_lo, out_hi;

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int t0      = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .op(op), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .out_lo(out_lo), .out_hi(out_hi),
    .zero(zero), .div0(div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         z;
    logic         d0;
    logic         iter;
  } res_t;

  function automatic res_t ref_res(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    res_t r;
    logic [SW-1:0] s;
    s = y[SW-1:0];
    r = '0;
    case (o)
      4'h0: r.lo = x & y;
      4'h1: r.lo = x | y;
      4'h2: r.lo = x + y;
      4'h3: r.lo = x ^ y;
      4'h6: r.lo = x - y;
      4'h7: r.lo = ($signed(x) < $signed(y)) ? 1 : 0;
      4'h8: r.lo = (x < y) ? 1 : 0;
      4'h9: r.lo = x << s;
      4'hA: r.lo = x >> s;
      4'hB: r.lo = $signed(x) >>> s;
      4'hC: r.lo = ~(x | y);
`ifdef ALU_MULDIV_EN
      4'hD: begin
        {r.hi, r.lo} = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r.iter = 1'b1;
      end
      4'hE: begin
        if (y == 0) begin
          r.lo = '1;
          r.hi = x;
          r.d0 = 1'b1;
        end else begin
          r.lo   = x / y;
          r.hi   = x % y;
          r.iter = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    r.z = (r.lo == 0);
    return r;
  endfunction

  // Model: is a result showing, and how many cycles until a pending one lands.
  logic m_valid = 1'b0;
  int   m_busy  = 0;
  res_t m_out   = '0;
  res_t m_pend  = '0;

  function automatic logic model_ready();
    if (flush) return 1'b0;
    if (m_busy > 0) return 1'b0;
    if (m_valid) return out_ready;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin : p_model
    res_t r;
    logic acc;
    if (rst) begin
      m_valid <= 1'b0;
      m_busy  <= 0;
      m_out   <= '0;
      m_pend  <= '0;
    end else begin
      acc = in_valid && model_ready();
      r   = ref_res(op, a, b);
      if (flush) begin
        m_valid <= 1'b0;
        m_busy  <= 0;
      end else if (acc && r.iter) begin
        m_valid <= 1'b0;
        m_busy  <= W;
        m_pend  <= r;
      end else if (acc) begin
        m_valid <= 1'b1;
        m_out   <= r;
      end else if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_valid <= 1'b1;
          m_out   <= m_pend;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1("cyc_out_valid", out_valid, m_valid);
    chk1("cyc_in_ready", in_ready, model_ready());
    chk("cyc_out_lo", out_lo, m_out.lo);
    chk("cyc_out_hi", out_hi, m_out.hi);
    chk1("cyc_zero", zero, m_out.z);
    chk1("cyc_div0", div0, m_out.d0);
  end

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n        = 0;
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk1("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic take(input string nm, input logic [W-1:0] lo, input logic [W-1:0] hi,
                      input logic z, input logic d0, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, W'(cyc - acc_cyc + 1), W'(lat));
    chk({nm, "_lo"}, out_lo, lo);
    chk({nm, "_hi"}, out_hi, hi);
    chk1({nm, "_zero"}, zero, z);
    chk1({nm, "_div0"}, div0, d0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lo", out_lo, '0);
    chk1("rst_valid", out_valid, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    send(4'h2, 32'h7FFF_FFFF, 32'd1);
    chk("add_lo", out_lo, 32'h8000_0000);
    chk1("add_zero", zero, 1'b0);
    chk1("add_valid_next", out_valid, 1'b1);
    send(4'h6, 32'd5, 32'd7);
    chk("sub_lo", out_lo, 32'hFFFF_FFFE);
    send(4'h6, 32'd9, 32'd9);
    chk1("sub_zero", zero, 1'b1);

    t0 = cyc;
    send(4'h7, 32'hFFFF_FFFF, 32'd1);
    chk("slt_lo", out_lo, 32'd1);
    send(4'h8, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_lo", out_lo, 32'd0);
    send(4'hB, 32'h8000_0000, 32'd4);
    chk("sra_lo", out_lo, 32'hF800_0000);
    chk("b2b_cycles", W'(cyc - t0), 32'd3);

    send(4'h0, 32'hF0F0_1234, 32'h0FF0_FF00);
    chk("and_lo", out_lo, 32'h00F0_1200);
    send(4'hC, 32'd0, 32'd0);
    chk("nor_lo", out_lo, 32'hFFFF_FFFF);
    send(4'h9, 32'd1, 32'd35);
    chk("sll_wrap_lo", out_lo, 32'd8);
    send(4'hA, 32'h8000_0000, 32'd31);
    chk("srl_lo", out_lo, 32'd1);
    send(4'hF, 32'h1234, 32'h5678);
    chk("rsvd_lo", out_lo, 32'd0);
    chk1("rsvd_zero", zero, 1'b1);
    @(posedge clk);
    #1;

`ifdef ALU_MULDIV_EN
    send(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take("multu_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1);
    send(4'hD, 32'd3, 32'd5);
    take("multu_small", 32'd15, 32'd0, 1'b0, 1'b0, W + 1);
    send(4'hE, 32'd100, 32'd7);
    take("divu", 32'd14, 32'd2, 1'b0, 1'b0, W + 1);
    send(4'hE, 32'hFFFF_FFFF, 32'd1);
    take("divu_by1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, W + 1);
    send(4'hE, 32'd100, 32'd0);
    take("divu_by0", 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b1, 1);
`else
    send(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    take("multu_off", 32'd0, 32'd0, 1'b1, 1'b0, 1);
    send(4'hE, 32'd100, 32'd7);
    take("divu_off", 32'd0, 32'd0, 1'b1, 1'b0, 1);
    send(4'hE, 32'd100, 32'd0);
    take("divu0_off", 32'd0, 32'd0, 1'b1, 1'b0, 1);
`endif

    out_ready = 1'b0;
    send(4'h2, 32'd3, 32'd4);
    repeat (5) begin
      @(negedge clk);
      chk1("stall_valid", out_valid, 1'b1);
      chk1("stall_ready", in_ready, 1'b0);
      chk("stall_lo", out_lo, 32'd7);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    t0 = cyc;
    send(4'h3, 32'h0000_00F0, 32'h0000_00FF);
    chk("resume_lo", out_lo, 32'h0000_000F);
    chk("resume_cycles", W'(cyc - t0), 32'd1);
    @(posedge clk);
    #1;

    send(4'hE, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    flush    = 1'b1;
    in_valid = 1'b1;
    op       = 4'h2;
    a        = 32'd5;
    b        = 32'd5;
    @(negedge clk);
    chk1("flush_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk1("flush_valid", out_valid, 1'b0);
`ifdef ALU_MULDIV_EN
    chk("flush_hold_lo", out_lo, 32'h0000_000F);
`else
    chk("flush_hold_lo", out_lo, 32'd0);
`endif
    repeat (40) @(posedge clk);
    #1;
    send(4'h2, 32'd1, 32'd1);
    chk("post_flush_add", out_lo, 32'd2);
    @(posedge clk);
    #1;

    send(4'hE, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk1("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_lo", out_lo, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(4'h2, 32'd1, 32'd1);
    chk("post_rst_add", out_lo, 32'd2);
    repeat (40) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 32-bit combinational ALU for the pipelined CPU EX stage. Single-cycle logic, arithmetic, compare and shift ops return one cycle after acceptance. Iterative unsigned multiply and divide produce a double-width HI/LO result over WIDTH cycles. Valid/ready handshakes on both sides let the hazard unit stall EX while a multi-cycle op is in flight.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8; shift amount is b[$clog2(WIDTH)-1:0].

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of any in-flight or held op
in_valid  in  1  operands and op presented
in_ready  out  1  block accepts on in_valid & in_ready
op  in  4  operation select, encoding below
a  in  WIDTH  operand A / dividend / multiplicand
b  in  WIDTH  operand B / divisor / multiplier / shift amount
out_valid  out  1  result held valid until out_ready
out_ready  in  1  consumer takes result
out_lo  out  WIDTH  result; MULTU low half; DIVU quotient
out_hi  out  WIDTH  MULTU high half; DIVU remainder; 0 for single-cycle ops
zero  out  1  out_lo == 0, valid with out_valid
div0  out  1  DIVU with b == 0; 0 for all other ops

Behaviour:
- Op encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 1100 NOR, 1101 MULTU, 1110 DIVU, 1111 reserved. Reserved op gives out_lo = 0, zero = 1.
- ADD/SUB: modulo 2^WIDTH; carry/overflow discarded. SLT/SLTU give 1 or 0 in bit 0, upper bits 0.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready = 1.
  - Accepting a single-cycle op goes to DONE next cycle with the result registered.
  - Accepting MULTU or DIVU goes to BUSY, loads the operands and sets cnt = WIDTH.
- BUSY: in_ready = 0. One shift-add (MULTU) or restoring-subtract (DIVU) step per cycle; cnt decrements each step. When cnt reaches 1, the step completes and the state moves to DONE. Accept at cycle N gives out_valid at N+WIDTH+1.
- DIVU with b == 0: skips BUSY and goes to DONE next cycle. Result: out_lo = all ones, out_hi = a, div0 = 1.
- DONE: out_valid = 1; outputs stable until handshake.
  - in_ready = out_ready, so back-to-back accept is allowed.
  - out_ready & in_valid: the new op is accepted and the state follows the IDLE rules.
  - out_ready & !in_valid: goes to IDLE.
  - !out_ready: stays in DONE.
- Throughput: one single-cycle op per clock while out_ready is held high.
- flush: highest priority. Next state is IDLE, out_valid = 0, cnt cleared. in_ready is forced to 0 in any cycle with flush = 1, so nothing is accepted.
- Reset, including mid-BUSY: state IDLE, out_valid 0, out_lo/out_hi 0, zero 0, div0 0, cnt 0; in_ready is 1 after rst deasserts.
- out_lo/out_hi/zero/div0 change only on acceptance completion or reset. They are not cleared on out_ready.

Optional Feature:
ALU_MULDIV_EN
- Defined: MULTU and DIVU are iterative as above.
- Undefined: no multiply/divide datapath or counter is built; BUSY is unreachable. MULTU/DIVU complete in one cycle like the reserved op: out_lo = 0, out_hi = 0, zero = 1, div0 = 0.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid next cycle, out_lo=0x80000000, zero=0. SUB 5-7 -> 0xFFFFFFFE. SUB 9-9 -> zero=1.
- SLT a=0xFFFFFFFF, b=1 -> out_lo=1; SLTU same operands -> out_lo=0; SRA 0x80000000 by b=4 -> 0xF8000000. Issue all three back-to-back; in_ready must stay 1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF accepted at cycle N -> in_ready=0 for cycles N+1..N+32, out_valid at N+33, out_hi=0xFFFFFFFE, out_lo=0x00000001.
- DIVU 100/7 -> out_lo=14, out_hi=2, div0=0. DIVU 100/0 -> out_valid one cycle after accept, out_lo=0xFFFFFFFF, out_hi=100, div0=1.
- Stall case: out_ready=0 for 5 cycles after a result -> out_valid and outputs stay stable, in_ready=0. On out_ready=1, a simultaneously presented op is accepted that cycle.
- flush or rst asserted mid-BUSY of a DIVU -> IDLE and out_valid=0 next edge (immediately for rst), no stale result delivered. A subsequent ADD 1+1 returns 2.
